// File: rtl/ber_test_controller.sv
// Sequences one symbol-error-rate measurement: clear pulse, settle interval,
// fixed counting window, then frozen results with a start/busy/done handshake.
module ber_test_controller #(
    parameter int CNT_W          = 22,
    parameter int WINDOW_SYMBOLS = 4194303,
    parameter int SETTLE_SYMBOLS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_clk_ena,
    input  logic             start,
    input  logic             abort,
    input  logic             sym_correct,
    input  logic             sym_error,
    output logic             clear_accumulator,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sym_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_saturated,
    output logic [1:0]       state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WINDOW_SYMBOLS);
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_SYMBOLS);

    logic [1:0]       state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic [CNT_W-1:0] sym_count_q, sym_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_sat_q, err_sat_d;
    logic             clear_q, clear_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             is_error_s;

    // A symbol flagged both correct and in error is still an error.
    assign is_error_s = sym_error | (sym_error & sym_correct);

    // Next-state and counter update; abort overrides everything and freezes counters.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        sym_count_d = sym_count_q;
        err_count_d = err_count_q;
        err_sat_d   = err_sat_q;
        clear_d     = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (start) begin
                        state_d     = S_SETTLE;
                        settle_d    = 8'd0;
                        sym_count_d = CNT_ZERO;
                        err_count_d = CNT_ZERO;
                        err_sat_d   = 1'b0;
                        clear_d     = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_SETTLE: begin
                    if (sym_clk_ena) begin
                        settle_d = settle_q + 8'd1;
                        if (settle_d == SETTLE_LAST) begin
                            state_d = S_MEASURE;
                        end else begin
                            state_d = S_SETTLE;
                        end
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
                S_MEASURE: begin
                    if (sym_clk_ena) begin
                        sym_count_d = sym_count_q + CNT_ONE;
                        if (is_error_s && (err_count_q != CNT_MAX)) begin
                            err_count_d = err_count_q + CNT_ONE;
                        end else begin
                            err_count_d = err_count_q;
                        end
                        err_sat_d = err_sat_q | (err_count_d == CNT_MAX);
                        if (sym_count_d == WIN_LAST) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_MEASURE;
                        end
                    end else begin
                        state_d = S_MEASURE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d == S_SETTLE) || (state_d == S_MEASURE);
        done_d = (state_d == S_HOLD);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            settle_q    <= 8'd0;
            sym_count_q <= CNT_ZERO;
            err_count_q <= CNT_ZERO;
            err_sat_q   <= 1'b0;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            sym_count_q <= sym_count_d;
            err_count_q <= err_count_d;
            err_sat_q   <= err_sat_d;
            clear_q     <= clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign clear_accumulator = clear_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign sym_count         = sym_count_q;
    assign err_count         = err_count_q;
    assign err_saturated     = err_sat_q;
    assign state             = state_q;

endmodule

// File: tb/tb_ber_test_controller.sv
// Directed bench for ber_test_controller: window 100, settle 4, strobe every 16 clk,
// plus a narrow 4-bit instance for error-counter saturation.
module tb_ber_test_controller;

    localparam int SET = 4;
    localparam int WIN = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, sym_clk_ena, start, abort, sym_correct, sym_error;
    logic clear_accumulator, busy, done, err_saturated;
    logic [21:0] sym_count, err_count;
    logic [1:0] state;

    logic start2;
    logic clear2, busy2, done2, sat2;
    logic [3:0] sym2, err2;
    logic [1:0] state2;

    int checks, fails;
    int phase, strobe_idx, err_mode, clear_cnt;

    ber_test_controller #(.CNT_W(22), .WINDOW_SYMBOLS(WIN), .SETTLE_SYMBOLS(SET)) dut (
        .clk(clk), .reset(reset), .sym_clk_ena(sym_clk_ena), .start(start), .abort(abort),
        .sym_correct(sym_correct), .sym_error(sym_error), .clear_accumulator(clear_accumulator),
        .busy(busy), .done(done), .sym_count(sym_count), .err_count(err_count),
        .err_saturated(err_saturated), .state(state));

    ber_test_controller #(.CNT_W(4), .WINDOW_SYMBOLS(15), .SETTLE_SYMBOLS(SET)) dut2 (
        .clk(clk), .reset(reset), .sym_clk_ena(sym_clk_ena), .start(start2), .abort(1'b0),
        .sym_correct(1'b0), .sym_error(1'b1), .clear_accumulator(clear2),
        .busy(busy2), .done(done2), .sym_count(sym2), .err_count(err2),
        .err_saturated(sat2), .state(state2));

    // One clock: sample just after the edge, then drive the next cycle's inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (clear_accumulator) clear_cnt++;
        phase = (phase + 1) % 16;
        sym_clk_ena = (phase == 0);
        if (sym_clk_ena) strobe_idx++;
        case (err_mode)
            0: sym_error = 1'b0;
            1: sym_error = !sym_clk_ena || (strobe_idx <= SET) || (((strobe_idx - SET) % 10) == 0);
            default: sym_error = 1'b1;
        endcase
        sym_correct = (err_mode == 1) ? 1'b1 : !sym_error;
    endtask

    task automatic do_start(input string name);
        start = 1'b1; abort = 1'b0; phase = 1; sym_clk_ena = 1'b0;
        strobe_idx = 0; clear_cnt = 0;
        tick();
        checks++;
        if (clear_accumulator !== 1'b1 || state !== 2'd1 || busy !== 1'b1 || done !== 1'b0 ||
            sym_count !== 22'd0 || err_count !== 22'd0 || err_saturated !== 1'b0) begin
            fails++;
            $display("FAIL %s_start: clr=%b st=%0d busy=%b done=%b sym=%0d err=%0d sat=%b, want clr=1 st=1 busy=1 done=0 sym=0 err=0 sat=0",
                     name, clear_accumulator, state, busy, done, sym_count, err_count, err_saturated);
        end
        start = 1'b0;
        tick();
        checks++;
        if (clear_accumulator !== 1'b0) begin
            fails++;
            $display("FAIL %s_clr_width: clear_accumulator=%b want 0", name, clear_accumulator);
        end
    endtask

    task automatic wait_done(input int exp_sym, input int exp_err, input string name);
        bit was_last = 1'b0;
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            was_last = sym_clk_ena && (strobe_idx == SET + WIN);
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_timeout: done=%b want 1 within 3000 clk", name, done);
        end else if (!was_last) begin
            fails++;
            $display("FAIL %s_latency: done rose at strobe_idx=%0d want one clk after strobe %0d", name, strobe_idx, SET + WIN);
        end
        checks++;
        if (sym_count !== 22'(exp_sym) || err_count !== 22'(exp_err) || busy !== 1'b0 || state !== 2'd3) begin
            fails++;
            $display("FAIL %s_result: sym=%0d err=%0d busy=%b st=%0d want sym=%0d err=%0d busy=0 st=3",
                     name, sym_count, err_count, busy, state, exp_sym, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (state !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || clear_accumulator !== 1'b0 ||
            sym_count !== 22'd0 || err_count !== 22'd0 || err_saturated !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: st=%0d busy=%b done=%b clr=%b sym=%0d err=%0d sat=%b want all 0",
                     state, busy, done, clear_accumulator, sym_count, err_count, err_saturated);
        end
        reset = 1'b0;
        do_start("pre_reset");
        repeat (300) tick();
        checks++;
        if (sym_count === 22'd0 || state !== 2'd2) begin
            fails++;
            $display("FAIL reset_precond: sym=%0d st=%0d want sym>0 st=2", sym_count, state);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || clear_accumulator !== 1'b0 ||
            sym_count !== 22'd0 || err_count !== 22'd0 || err_saturated !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: st=%0d busy=%b sym=%0d err=%0d want all 0", state, busy, sym_count, err_count);
        end
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (state !== 2'd0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL idle_after_reset: st=%0d busy=%b want st=0 busy=0", state, busy);
            end
        end
    endtask

    task automatic test_clean_run();
        err_mode = 0;
        do_start("clean");
        while (strobe_idx < SET + 1) tick();
        checks++;
        if (state !== 2'd2 || sym_count !== 22'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL settle_skip: st=%0d sym=%0d busy=%b want st=2 sym=0 busy=1", state, sym_count, busy);
        end
        wait_done(WIN, 0, "clean");
        for (int i = 0; i < 1000; i++) begin
            tick();
            checks++;
            if (done !== 1'b1 || sym_count !== 22'd100 || err_count !== 22'd0 || clear_accumulator !== 1'b0) begin
                fails++;
                $display("FAIL hold_frozen: done=%b sym=%0d err=%0d clr=%b want done=1 sym=100 err=0 clr=0",
                         done, sym_count, err_count, clear_accumulator);
            end
        end
    endtask

    task automatic test_errors_on_strobes();
        err_mode = 1;
        do_start("errors");
        wait_done(WIN, 10, "errors");
        err_mode = 0;
    endtask

    task automatic test_abort_collision();
        err_mode = 0;
        do_start("abort");
        for (int i = 0; i < 2000 && !(strobe_idx == SET + 37 && !sym_clk_ena); i++) tick();
        checks++;
        if (sym_count !== 22'd37) begin
            fails++;
            $display("FAIL abort_precond: sym=%0d want 37", sym_count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (state !== 2'd0 || sym_count !== 22'd37 || done !== 1'b0 || busy !== 1'b0 || clear_accumulator !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: st=%0d sym=%0d done=%b busy=%b clr=%b want st=0 sym=37 done=0 busy=0 clr=0",
                     state, sym_count, done, busy, clear_accumulator);
        end
        repeat (40) tick();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (state !== 2'd0 || clear_accumulator !== 1'b0 || sym_count !== 22'd37 || busy !== 1'b0) begin
            fails++;
            $display("FAIL start_abort: st=%0d clr=%b sym=%0d busy=%b want st=0 clr=0 sym=37 busy=0",
                     state, clear_accumulator, sym_count, busy);
        end
        tick();
        checks++;
        if (state !== 2'd0 || clear_accumulator !== 1'b0) begin
            fails++;
            $display("FAIL start_abort_after: st=%0d clr=%b want st=0 clr=0", state, clear_accumulator);
        end
    endtask

    task automatic test_start_while_busy();
        do_start("busy");
        while (strobe_idx < 2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (clear_accumulator !== 1'b0 || state !== 2'd1) begin
            fails++;
            $display("FAIL start_in_settle: clr=%b st=%0d want clr=0 st=1", clear_accumulator, state);
        end
        while (strobe_idx < 50) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (clear_accumulator !== 1'b0 || state !== 2'd2 || sym_count === 22'd0) begin
            fails++;
            $display("FAIL start_in_measure: clr=%b st=%0d sym=%0d want clr=0 st=2 sym>0", clear_accumulator, state, sym_count);
        end
        wait_done(WIN, 0, "busy");
        checks++;
        if (clear_cnt !== 1) begin
            fails++;
            $display("FAIL single_clear: clear pulses=%0d want 1", clear_cnt);
        end
        do_start("restart");
        wait_done(WIN, 0, "restart");
    endtask

    task automatic test_back_to_back();
        start = 1'b1; phase = 1; sym_clk_ena = 1'b0; strobe_idx = 0; clear_cnt = 0;
        repeat (40) tick();
        start = 1'b0;
        checks++;
        if (clear_cnt !== 1 || busy !== 1'b1 || state !== 2'd1) begin
            fails++;
            $display("FAIL held_start: clear pulses=%0d busy=%b st=%0d want 1 pulse busy=1 st=1", clear_cnt, busy, state);
        end
        wait_done(WIN, 0, "held");
    endtask

    task automatic test_saturation();
        bit seen = 1'b0;
        err_mode = 2;
        start2 = 1'b1; phase = 1; sym_clk_ena = 1'b0; strobe_idx = 0;
        tick();
        start2 = 1'b0;
        checks++;
        if (clear2 !== 1'b1 || sym2 !== 4'd0 || err2 !== 4'd0 || sat2 !== 1'b0 || busy2 !== 1'b1) begin
            fails++;
            $display("FAIL sat_start: clr=%b sym=%0d err=%0d sat=%b busy=%b want 1 0 0 0 1", clear2, sym2, err2, sat2, busy2);
        end
        for (int i = 0; i < 2000 && !seen; i++) begin
            tick();
            if (done2 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || sym2 !== 4'd15 || err2 !== 4'd15 || sat2 !== 1'b1 || state2 !== 2'd3) begin
            fails++;
            $display("FAIL saturation: done=%b sym=%0d err=%0d sat=%b st=%0d want done=1 sym=15 err=15 sat=1 st=3",
                     done2, sym2, err2, sat2, state2);
        end
        repeat (64) tick();
        checks++;
        if (err2 !== 4'd15 || sat2 !== 1'b1 || done2 !== 1'b1) begin
            fails++;
            $display("FAIL sat_hold: err=%0d sat=%b done=%b want 15 1 1", err2, sat2, done2);
        end
        err_mode = 0;
    endtask

    initial begin
        checks = 0; fails = 0; phase = 0; strobe_idx = 0; err_mode = 0; clear_cnt = 0;
        reset = 1'b1; sym_clk_ena = 1'b0; start = 1'b0; abort = 1'b0;
        sym_correct = 1'b0; sym_error = 1'b0; start2 = 1'b0;
        test_reset();
        test_clean_run();
        test_errors_on_strobes();
        test_abort_collision();
        test_start_while_busy();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
